rffe_beat_if: RTL
=================

# rffe_beat_if

Parametrised, single-clock beat-multiplexed converter interface for the RF front end: it serialises TX samples into BEATS narrow beats per sample and deserialises RX beats into samples. It generalises the fixed 12-bit/6-bit AD9866 interface with a valid/ready TX handshake, underrun detection, RX sync-loss detection and relock, and parametrised level detection. It sits between the DSP sample streams and the AD9866 pins, clocked at the beat rate.

## Interface
- SAMPLE_W, 12, sample width; must be an integer multiple of BEAT_W.
- BEAT_W, 6, pin-bus width per beat; BEATS = SAMPLE_W/BEAT_W, BEATS ≥ 2.
- GOOD_BITS, 3, number of MSBs examined for good-level detection; 2 ≤ GOOD_BITS ≤ SAMPLE_W.
- clk  in  1  beat-rate clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tx_en  in  1  transmit enable.
- tx_data  in  SAMPLE_W  TX sample, two's complement.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  sample load slot; transfer occurs on tx_valid & tx_ready.
- tx_underrun  out  1  sticky: load slot passed without tx_valid.
- rx_data  out  SAMPLE_W  assembled RX sample.
- rx_valid  out  1  one-cycle pulse per new rx_data.
- rx_locked  out  1  RX beat alignment established.
- rx_sync_err  out  1  sticky: rxsync spacing violation.
- rxclip  out  1  sticky: full-scale RX sample seen.
- rxgoodlvl  out  1  sticky: good-level RX sample seen.
- rxclrstatus  in  1  clears all sticky flags.
- rx_clip_cnt  out  16  saturating clip count (see Configuration).
- rffe_ad9866_tx  out  BEAT_W  TX beat bus.
- rffe_ad9866_txsync  out  1  high on last (LSB) TX beat.
- rffe_ad9866_txquiet_n  out  1  equals registered tx_en.
- rffe_ad9866_rx  in  BEAT_W  RX beat bus, synchronous to clk.
- rffe_ad9866_rxsync  in  1  high with last (LSB) RX beat.
- rffe_ad9866_mode  out  1  constant 1 (full-duplex beat mode).

## Operation
- TX: tx_en registered to tx_en_d1. Beat counter bc counts 0..BEATS-1 while tx_en_d1 is high and is held at BEATS-1 while it is low.
- tx_ready = tx_en_d1 & (bc == BEATS-1). In a ready cycle, tx_valid loads tx_data; ~tx_valid loads zeros and sets tx_underrun.
- Beats are sent MSB beat first: beat k = sample[SAMPLE_W-1-k·BEAT_W -: BEAT_W]. txsync is 1 only on beat BEATS-1.
- tx_en_d1 low: rffe_ad9866_tx=0, txsync=0, txquiet_n=0. Any in-flight sample is aborted the cycle after tx_en_d1 falls.
- RX: pins registered once (rx_d1, rxsync_d1). A shift register accumulates beats, oldest at MSB.
- rxsync_d1 while rx_locked: rx_data <= {previous BEATS-1 beats, rx_d1}, rx_valid pulses.
- Sync FSM states: UNLOCKED and LOCKED.
  - UNLOCKED → LOCKED on the first rxsync_d1. No sample is emitted on that edge. The spacing counter is cleared.
  - LOCKED: rxsync_d1 expected exactly every BEATS cycles. Early rxsync, or BEATS cycles without one, sets rx_sync_err → UNLOCKED. An early rxsync also counts as the first sync of relock, so the block is LOCKED again immediately with no emit.
- Level detect, evaluated on each rx_valid:
  - clip = sample is 0 followed by all 1s, or 1 followed by all 0s.
  - good = top GOOD_BITS equal 0 followed by 1s, or 1 followed by 0s.
- Sticky flags: rxclrstatus clears tx_underrun, rx_sync_err, rxclip and rxgoodlvl. A set in the same cycle wins over the clear.

## Timing
- Reset values: all outputs 0 except rffe_ad9866_mode=1. FSM resets to UNLOCKED. bc resets to BEATS-1.
- tx_en rising at cycle c: tx_ready first high at c+1, then every BEATS cycles.
- Sample accepted at cycle t: MSB beat on the pins at t+1, LSB beat with txsync at t+BEATS. Back-to-back samples give a gapless beat stream.
- RX latency: LSB beat on the pins at cycle r → rx_valid and rx_data at r+2. rx_data holds until the next rx_valid.
- Flags: set visible one cycle after the causing rx_valid or ready slot.
- Reset mid-sample: outputs reach reset values on the next edge, with no partial beat.

## Configuration
- RFFE_BEAT_IF_CLIPCNT_EN defined: rx_clip_cnt increments on each clipped rx_valid, saturates at 16'hFFFF, and clears on rxclrstatus. A clip in the same cycle as the clear loads 1.
- Not defined: rx_clip_cnt is tied to 0 and no counter logic is built.

## Test plan
- Defaults, tx_en=1, tx_valid=1, samples 12'hABC then 12'h123 → pins 6'h2A, 6'h3C(txsync=1), 6'h04, 6'h23(txsync=1); tx_ready duty 1/2.
- tx_valid held 0 over one ready slot → zero beats sent, tx_underrun=1. Then rxclrstatus pulse → tx_underrun=0.
- RX beats 6'h1F, 6'h3F with rxsync on the second beat, repeated after lock → rx_data=12'h7FF, rxclip=1, rxgoodlvl=1, rx_clip_cnt=1 (macro on).
- Locked, then rxsync withheld for 3 cycles → rx_sync_err=1, rx_locked=0. The next rxsync relocks with no rx_valid, and the following sync emits.
- SAMPLE_W=16, BEAT_W=4: sample 16'h8001 → beats 8,0,0,1 with txsync on the 4th. RX loopback of those beats yields 16'h8001 and rxclip=0.
- rst asserted mid-sample with rxclip set and tx active → next cycle all outputs 0, mode=1; tx_ready returns 1 cycle after tx_en_d1 re-registers.

Source files
------------

// File: rtl/rffe_beat_if.sv
// Beat-multiplexed AD9866 port: TX samples leave as BEATS beats MSB first (+1 cycle), RX beats return as samples (+2 cycles).
// TX backpressure is the tx_ready load slot once per BEATS cycles; RFFE_BEAT_IF_CLIPCNT_EN adds a saturating clip counter.
module rffe_beat_if #(
  parameter int SAMPLE_W  = 12,
  parameter int BEAT_W    = 6,
  parameter int GOOD_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_en,
  input  logic [SAMPLE_W-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic [SAMPLE_W-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_locked,
  output logic                rx_sync_err,
  output logic                rxclip,
  output logic                rxgoodlvl,
  input  logic                rxclrstatus,
  output logic [15:0]         rx_clip_cnt,
  output logic [BEAT_W-1:0]   rffe_ad9866_tx,
  output logic                rffe_ad9866_txsync,
  output logic                rffe_ad9866_txquiet_n,
  input  logic [BEAT_W-1:0]   rffe_ad9866_rx,
  input  logic                rffe_ad9866_rxsync,
  output logic                rffe_ad9866_mode
);
  localparam int BEATS = SAMPLE_W / BEAT_W;
  localparam int CW    = $clog2(BEATS);
  localparam int SHW   = SAMPLE_W - BEAT_W;
  localparam logic [CW-1:0]        LAST     = CW'(BEATS - 1);
  localparam logic [SAMPLE_W-1:0]  CLIP_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0]  CLIP_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [GOOD_BITS-1:0] GOOD_POS = {1'b0, {(GOOD_BITS-1){1'b1}}};
  localparam logic [GOOD_BITS-1:0] GOOD_NEG = {1'b1, {(GOOD_BITS-1){1'b0}}};

  typedef enum logic {UNLOCKED, LOCKED} sync_state_e;

  logic                tx_en_d1_q, tx_en_d1_d;
  logic [CW-1:0]       bc_q, bc_d;
  logic [SAMPLE_W-1:0] tx_sample_q, tx_sample_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic [BEAT_W-1:0]   tx_beat;
  logic [BEAT_W-1:0]   rx_d1_q, rx_d1_d;
  logic                rxsync_d1_q, rxsync_d1_d;
  logic [SHW-1:0]      rx_sh_q, rx_sh_d;
  logic [SAMPLE_W-1:0] rx_word;
  logic [SAMPLE_W-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  sync_state_e         state_q, state_d;
  logic [CW-1:0]       sp_cnt_q, sp_cnt_d;
  logic                rx_sync_err_q, rx_sync_err_d;
  logic                rxclip_q, rxclip_d;
  logic                rxgoodlvl_q, rxgoodlvl_d;
  logic                emit, sync_err_set, clip_hit, good_hit;

  always_comb begin
    tx_ready    = tx_en_d1_q && (bc_q == LAST);
    tx_en_d1_d  = tx_en;
    bc_d        = tx_en_d1_q ? ((bc_q == LAST) ? '0 : bc_q + 1'b1) : LAST;
    tx_sample_d = tx_sample_q;
    if (!tx_en_d1_q)   tx_sample_d = '0;
    else if (tx_ready) tx_sample_d = tx_valid ? tx_data : '0;
    tx_underrun_d = (tx_underrun_q && !rxclrstatus) || (tx_ready && !tx_valid);
    tx_beat = '0;
    for (int k = 0; k < BEATS; k++)
      if (bc_q == CW'(k)) tx_beat = tx_sample_q[SAMPLE_W-1-k*BEAT_W -: BEAT_W];
  end

  // Spacing counter reads BEATS-1 exactly on the cycle a well-timed rxsync is due.
  always_comb begin
    rx_d1_d      = rffe_ad9866_rx;
    rxsync_d1_d  = rffe_ad9866_rxsync;
    rx_word      = {rx_sh_q, rx_d1_q};
    rx_sh_d      = rx_word[SHW-1:0];
    state_d      = state_q;
    sp_cnt_d     = sp_cnt_q;
    emit         = 1'b0;
    sync_err_set = 1'b0;
    case (state_q)
      UNLOCKED: if (rxsync_d1_q) begin
        state_d  = LOCKED;
        sp_cnt_d = '0;
      end
      LOCKED: if (rxsync_d1_q) begin
        sp_cnt_d = '0;
        if (sp_cnt_q == LAST) emit = 1'b1;
        else                  sync_err_set = 1'b1;
      end else if (sp_cnt_q == LAST) begin
        sync_err_set = 1'b1;
        state_d      = UNLOCKED;
      end else begin
        sp_cnt_d = sp_cnt_q + 1'b1;
      end
      default: state_d = UNLOCKED;
    endcase
    rx_valid_d    = emit;
    rx_data_d     = emit ? rx_word : rx_data_q;
    clip_hit      = rx_valid_q && (rx_data_q == CLIP_POS || rx_data_q == CLIP_NEG);
    good_hit      = rx_valid_q && (rx_data_q[SAMPLE_W-1 -: GOOD_BITS] == GOOD_POS ||
                                   rx_data_q[SAMPLE_W-1 -: GOOD_BITS] == GOOD_NEG);
    rx_sync_err_d = (rx_sync_err_q && !rxclrstatus) || sync_err_set;
    rxclip_d      = (rxclip_q && !rxclrstatus) || clip_hit;
    rxgoodlvl_d   = (rxgoodlvl_q && !rxclrstatus) || good_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_d1_q    <= 1'b0;
      bc_q          <= LAST;
      tx_sample_q   <= '0;
      tx_underrun_q <= 1'b0;
      rx_d1_q       <= '0;
      rxsync_d1_q   <= 1'b0;
      rx_sh_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      state_q       <= UNLOCKED;
      sp_cnt_q      <= '0;
      rx_sync_err_q <= 1'b0;
      rxclip_q      <= 1'b0;
      rxgoodlvl_q   <= 1'b0;
    end else begin
      tx_en_d1_q    <= tx_en_d1_d;
      bc_q          <= bc_d;
      tx_sample_q   <= tx_sample_d;
      tx_underrun_q <= tx_underrun_d;
      rx_d1_q       <= rx_d1_d;
      rxsync_d1_q   <= rxsync_d1_d;
      rx_sh_q       <= rx_sh_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      state_q       <= state_d;
      sp_cnt_q      <= sp_cnt_d;
      rx_sync_err_q <= rx_sync_err_d;
      rxclip_q      <= rxclip_d;
      rxgoodlvl_q   <= rxgoodlvl_d;
    end
  end

`ifdef RFFE_BEAT_IF_CLIPCNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (rxclrstatus)                             clip_cnt_d = clip_hit ? 16'd1 : 16'd0;
    else if (clip_hit && clip_cnt_q != 16'hFFFF) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) clip_cnt_q <= '0;
    else     clip_cnt_q <= clip_cnt_d;
  end

  assign rx_clip_cnt = clip_cnt_q;
`else
  assign rx_clip_cnt = 16'd0;
`endif

  assign tx_underrun           = tx_underrun_q;
  assign rx_data               = rx_data_q;
  assign rx_valid              = rx_valid_q;
  assign rx_locked             = (state_q == LOCKED);
  assign rx_sync_err           = rx_sync_err_q;
  assign rxclip                = rxclip_q;
  assign rxgoodlvl             = rxgoodlvl_q;
  assign rffe_ad9866_tx        = tx_en_d1_q ? tx_beat : '0;
  assign rffe_ad9866_txsync    = tx_ready;
  assign rffe_ad9866_txquiet_n = tx_en_d1_q;
  assign rffe_ad9866_mode      = 1'b1;
endmodule
